// File: rtl/sram_pins_pkg.sv
// sram_pins_pkg: shared state encoding, default geometry/timing and error bit positions
// for the on-chip asynchronous SRAM device model.
package sram_pins_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        IDLE,
        READ_ACCESS,
        READ_DRIVE,
        READ_HOLD,
        WRITE_PULSE,
        WRITE_WAIT
    } sram_state_e;

    localparam int DATA_W = 16;
    localparam int PIN_AW = 21;

    localparam int DEF_MEM_AW      = 10;
    localparam int DEF_RD_LAT      = 2;
    localparam int DEF_WR_MIN      = 3;
    localparam int DEF_POWERUP_CYC = 40000;

    localparam int ERR_PWRUP    = 0;
    localparam int ERR_SHORT_WR = 1;
    localparam int ERR_ADDR_WR  = 2;

endpackage

// File: rtl/async_sram_responder_if.sv
// async_sram_responder_if: SRAM pin bundle (address + active-low controls) from the controller,
// plus the device's per-lane read drive view of the data pins.
interface async_sram_responder_if;
    import sram_pins_pkg::*;

    logic [PIN_AW-1:0] i_sram_address;
    logic              i_CS;
    logic              i_OE;
    logic              i_WE;
    logic              i_UB;
    logic              i_LB;
    logic [DATA_W-1:0] dq_out;
    logic [1:0]        dq_drv;

    modport master (
        output i_sram_address, i_CS, i_OE, i_WE, i_UB, i_LB,
        input  dq_out, dq_drv
    );

    modport slave (
        input  i_sram_address, i_CS, i_OE, i_WE, i_UB, i_LB,
        output dq_out, dq_drv
    );

endinterface

// File: rtl/sram_byte_lane_mem.sv
// sram_byte_lane_mem: 2^MEM_AW x 16 dual-port RAM; port A read/write with byte enables,
// port B registered read-only backdoor. Both ports are read-first.
module sram_byte_lane_mem
    import sram_pins_pkg::*;
#(
    parameter int MEM_AW = DEF_MEM_AW
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              a_we,
    input  logic [1:0]        a_be,
    input  logic [MEM_AW-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [MEM_AW-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge i_clk) begin
        if (a_we && a_be[1]) mem[a_addr][15:8] <= a_wdata[15:8];
        if (a_we && a_be[0]) mem[a_addr][7:0]  <= a_wdata[7:0];
        a_rdata <= mem[a_addr];
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) b_rdata <= '0;
        else        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/async_sram_responder.sv
// async_sram_responder: pin-level 16-bit async SRAM device in the i_clk domain. Times read
// latency and write pulse width, drives byte lanes on reads, and flags protocol errors.
module async_sram_responder
    import sram_pins_pkg::*;
#(
    parameter int MEM_AW      = DEF_MEM_AW,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int WR_MIN      = DEF_WR_MIN,
    parameter int POWERUP_CYC = DEF_POWERUP_CYC
) (
    input  logic                  i_clk,
    input  logic                  reset,
    async_sram_responder_if.slave sram,
    inout  wire  [DATA_W-1:0]     io_sram_data,
    input  logic [MEM_AW-1:0]     i_bd_addr,
    output logic [DATA_W-1:0]     o_bd_data,
    output logic                  o_ready,
    output logic [2:0]            o_err,
    output logic [15:0]           o_wr_count,
    output logic [15:0]           o_rd_count
);

    localparam int              PU_W    = $clog2(POWERUP_CYC + 1);
    localparam logic [PU_W-1:0] PU_LAST = PU_W'(POWERUP_CYC - 1);

    sram_state_e       state;
    logic [2:0]        cnt;
    logic [PU_W-1:0]   pu_cnt;
    logic              commit_p1;
    logic [PIN_AW-1:0] lat_addr;
    logic [DATA_W-1:0] wr_data_cap;
    logic [1:0]        wr_be_cap;
    logic [DATA_W-1:0] hold_data;
    logic [1:0]        hold_lanes;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] dq_out;
    logic [1:0]        dq_drv;
    logic              cs_n, oe_n, we_n, addr_same;

    assign cs_n      = sram.i_CS;
    assign oe_n      = sram.i_OE;
    assign we_n      = sram.i_WE;
    assign addr_same = (sram.i_sram_address == lat_addr);

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state      <= POWERUP;
            cnt        <= '0;
            pu_cnt     <= '0;
            commit_p1  <= 1'b0;
            o_ready    <= 1'b0;
            o_err      <= '0;
            o_wr_count <= '0;
            o_rd_count <= '0;
        end else begin
            commit_p1 <= 1'b0;
            case (state)
                POWERUP: begin
                    if (!cs_n) o_err[ERR_PWRUP] <= 1'b1;
                    if (pu_cnt == PU_LAST) begin
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        pu_cnt <= pu_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!cs_n && !we_n) begin
                        state <= WRITE_PULSE;
                        cnt   <= 3'd1;
                    end else if (!cs_n && !oe_n) begin
                        state <= READ_ACCESS;
                        cnt   <= 3'd0;
                    end
                end
                READ_ACCESS: begin
                    if (cs_n || oe_n || !we_n)   state <= IDLE;
                    else if (!addr_same)         cnt   <= 3'd1;
                    else if (cnt == 3'(RD_LAT))  state <= READ_DRIVE;
                    else                         cnt   <= cnt + 3'd1;
                end
                READ_DRIVE: begin
                    // End of the read cycle wins over a late address change so the hold phase still happens.
                    if (cs_n || oe_n || !we_n) begin
                        state      <= READ_HOLD;
                        o_rd_count <= o_rd_count + 16'd1;
                    end else if (!addr_same) begin
                        state <= READ_ACCESS;
                        cnt   <= 3'd1;
                    end
                end
                READ_HOLD: state <= IDLE;
                WRITE_PULSE: begin
                    if (cs_n || we_n) begin
                        state <= IDLE;
                        if (cnt >= 3'(WR_MIN)) begin
                            commit_p1  <= 1'b1;
                            o_wr_count <= o_wr_count + 16'd1;
                        end else begin
                            o_err[ERR_SHORT_WR] <= 1'b1;
                        end
                    end else if (!addr_same) begin
                        o_err[ERR_ADDR_WR] <= 1'b1;
                        state              <= WRITE_WAIT;
                    end else if (cnt != 3'd7) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE_WAIT: if (cs_n && we_n) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // lat_addr stays put through the commit cycle, so it doubles as the RAM write address.
    always_ff @(posedge i_clk) begin
        if (state == IDLE || state == READ_ACCESS || state == READ_DRIVE)
            lat_addr <= sram.i_sram_address;
        if ((state == IDLE || state == WRITE_PULSE) && !cs_n && !we_n) begin
            wr_data_cap <= io_sram_data;
            wr_be_cap   <= {~sram.i_UB, ~sram.i_LB};
        end
        if (state == READ_DRIVE) begin
            hold_data  <= rd_q;
            hold_lanes <= {~sram.i_UB, ~sram.i_LB};
        end
    end

    sram_byte_lane_mem #(.MEM_AW(MEM_AW)) u_mem (
        .i_clk   (i_clk),
        .reset   (reset),
        .a_we    (commit_p1),
        .a_be    (wr_be_cap),
        .a_addr  (lat_addr[MEM_AW-1:0]),
        .a_wdata (wr_data_cap),
        .a_rdata (rd_q),
        .b_addr  (i_bd_addr),
        .b_rdata (o_bd_data)
    );

    always_comb begin
        dq_out = rd_q;
        dq_drv = 2'b00;
        if (state == READ_DRIVE) begin
            dq_drv = {~sram.i_UB, ~sram.i_LB};
        end else if (state == READ_HOLD) begin
            dq_out = hold_data;
            dq_drv = hold_lanes;
        end
    end

    assign sram.dq_out        = dq_out;
    assign sram.dq_drv        = dq_drv;
    assign io_sram_data[15:8] = dq_drv[1] ? dq_out[15:8] : 8'bz;
    assign io_sram_data[7:0]  = dq_drv[0] ? dq_out[7:0]  : 8'bz;

endmodule

// File: tb/tb_async_sram_responder.sv
// tb_async_sram_responder: directed and randomized pin-level transactions against a
// word/lane reference memory with expected counters and sticky error bits.
module tb_async_sram_responder;
    import sram_pins_pkg::*;

    localparam int MEM_AW      = 10;
    localparam int RD_LAT      = 2;
    localparam int WR_MIN      = 3;
    localparam int POWERUP_CYC = 40000;

    logic              clk;
    logic              reset;
    logic [15:0]       tb_dq;
    logic              tb_dq_en;
    wire  [15:0]       io_sram_data;
    logic [MEM_AW-1:0] bd_addr;
    logic [15:0]       bd_data;
    logic              ready;
    logic [2:0]        err;
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;

    int          vectors;
    int          miscompares;
    logic [15:0] ref_mem [1024];
    logic [1:0]  ref_vld [1024];
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    logic [2:0]  exp_err;

    async_sram_responder_if sif ();

    assign io_sram_data = tb_dq_en ? tb_dq : 16'bz;

    async_sram_responder #(
        .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_MIN(WR_MIN), .POWERUP_CYC(POWERUP_CYC)
    ) dut (
        .i_clk        (clk),
        .reset        (reset),
        .sram         (sif),
        .io_sram_data (io_sram_data),
        .i_bd_addr    (bd_addr),
        .o_bd_data    (bd_data),
        .o_ready      (ready),
        .o_err        (err),
        .o_wr_count   (wr_count),
        .o_rd_count   (rd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pins_idle();
        sif.i_sram_address = '0;
        sif.i_CS = 1'b1; sif.i_OE = 1'b1; sif.i_WE = 1'b1;
        sif.i_UB = 1'b0; sif.i_LB = 1'b0;
        tb_dq_en = 1'b0; tb_dq = '0;
    endtask

    // Write of ncyc WE-low cycles; the reference commits only lanes with UB/LB low and only if long enough.
    task automatic do_write(input logic [20:0] a, input logic [15:0] d, input logic ub, input logic lb,
                            input int ncyc);
        int idx;
        idx = int'(a[MEM_AW-1:0]);
        sif.i_sram_address = a; tb_dq = d; tb_dq_en = 1'b1;
        sif.i_UB = ub; sif.i_LB = lb; sif.i_OE = 1'b1;
        sif.i_CS = 1'b0; sif.i_WE = 1'b0;
        repeat (ncyc) step();
        sif.i_CS = 1'b1; sif.i_WE = 1'b1;
        step();
        tb_dq_en = 1'b0;
        if (ncyc >= WR_MIN) begin
            exp_wr = exp_wr + 16'd1;
            if (!ub) begin ref_mem[idx][15:8] = d[15:8]; ref_vld[idx][1] = 1'b1; end
            if (!lb) begin ref_mem[idx][7:0]  = d[7:0];  ref_vld[idx][0] = 1'b1; end
        end else begin
            exp_err[1] = 1'b1;
        end
    endtask

    // Read cycle: returns whether anything drove early, the first valid beat, the hold beat and the lanes after hold.
    task automatic do_read(input logic [20:0] a, input logic ub, input logic lb,
                           output logic early, output logic [15:0] d, output logic [1:0] drv,
                           output logic [15:0] hd, output logic [1:0] hdrv, output logic [1:0] zdrv);
        sif.i_sram_address = a; sif.i_UB = ub; sif.i_LB = lb;
        sif.i_WE = 1'b1; sif.i_CS = 1'b0; sif.i_OE = 1'b0;
        early = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            step();
            if (sif.dq_drv !== 2'b00) early = 1'b1;
        end
        step();
        d = io_sram_data; drv = sif.dq_drv;
        sif.i_CS = 1'b1; sif.i_OE = 1'b1;
        step();
        hd = io_sram_data; hdrv = sif.dq_drv;
        step();
        zdrv = sif.dq_drv;
        exp_rd = exp_rd + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pins_idle();
        bd_addr = '0;
        repeat (3) step();
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL reset_err got %b want 000", err); end
        vectors++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
            miscompares++; $display("FAIL reset_counts got %0d/%0d want 0/0", wr_count, rd_count); end
        vectors++; if (bd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_bd got %h want 0000", bd_data); end
        vectors++; if (sif.dq_drv !== 2'b00) begin miscompares++; $display("FAIL reset_bus got %b want 00", sif.dq_drv); end
        reset = 1'b1;
        for (int cyc = 1; cyc <= POWERUP_CYC; cyc++) begin
            if (cyc == 100) begin
                sif.i_sram_address = 21'h00012; tb_dq = 16'hDEAD; tb_dq_en = 1'b1;
                sif.i_CS = 1'b0; sif.i_WE = 1'b0;
            end
            if (cyc == 105) pins_idle();
            step();
            if (cyc == POWERUP_CYC - 1) begin
                vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL pwrup_early got %b want 0", ready); end
            end
        end
        exp_err = 3'b001;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL pwrup_ready got %b want 1", ready); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL pwrup_err got %b want %b", err, exp_err); end
        vectors++; if (wr_count !== 16'd0) begin miscompares++; $display("FAIL pwrup_nowrite got %0d want 0", wr_count); end
    endtask

    task automatic test_write();
        bd_addr = 10'h012;
        do_write(21'h00012, 16'hA55A, 1'b0, 1'b0, 3);
        vectors++; if (wr_count !== exp_wr) begin miscompares++; $display("FAIL wr_count got %0d want %0d", wr_count, exp_wr); end
        step(); step();
        vectors++; if (bd_data !== 16'hA55A) begin miscompares++; $display("FAIL wr_backdoor got %h want a55a", bd_data); end
    endtask

    task automatic test_read();
        logic e; logic [15:0] d, hd; logic [1:0] drv, hdrv, zdrv;
        do_read(21'h00012, 1'b0, 1'b0, e, d, drv, hd, hdrv, zdrv);
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL rd_latency got early drive want none"); end
        vectors++; if (d !== 16'hA55A || drv !== 2'b11) begin
            miscompares++; $display("FAIL rd_data got %h/%b want a55a/11", d, drv); end
        vectors++; if (hd !== 16'hA55A || hdrv !== 2'b11) begin
            miscompares++; $display("FAIL rd_hold got %h/%b want a55a/11", hd, hdrv); end
        vectors++; if (zdrv !== 2'b00) begin miscompares++; $display("FAIL rd_turnaround got %b want 00", zdrv); end
        vectors++; if (rd_count !== exp_rd) begin miscompares++; $display("FAIL rd_count got %0d want %0d", rd_count, exp_rd); end
    endtask

    task automatic test_byte_lanes();
        logic e; logic [15:0] d, hd; logic [1:0] drv, hdrv, zdrv;
        bd_addr = 10'h012;
        do_write(21'h00012, 16'h1234, 1'b1, 1'b0, 3);
        step();
        vectors++; if (bd_data !== 16'hA55A) begin miscompares++; $display("FAIL bd_old_data got %h want a55a", bd_data); end
        step();
        vectors++; if (bd_data !== 16'hA534) begin miscompares++; $display("FAIL lane_merge got %h want a534", bd_data); end
        do_read(21'h00012, 1'b0, 1'b1, e, d, drv, hd, hdrv, zdrv);
        vectors++; if (drv !== 2'b10 || d[15:8] !== 8'hA5) begin
            miscompares++; $display("FAIL rd_upper_lane got %h/%b want a5xx/10", d, drv); end
        vectors++; if (hdrv !== 2'b10 || zdrv !== 2'b00) begin
            miscompares++; $display("FAIL rd_upper_hold got %b then %b want 10 then 00", hdrv, zdrv); end
    endtask

    task automatic test_errors();
        bd_addr = 10'h012;
        do_write(21'h00012, 16'hFFFF, 1'b0, 1'b0, 2);
        step(); step();
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL short_wr_err got %b want %b", err, exp_err); end
        vectors++; if (bd_data !== 16'hA534 || wr_count !== exp_wr) begin
            miscompares++; $display("FAIL short_wr_nocommit got %h/%0d want a534/%0d", bd_data, wr_count, exp_wr); end
        sif.i_sram_address = 21'h00012; tb_dq = 16'h0000; tb_dq_en = 1'b1;
        sif.i_UB = 1'b0; sif.i_LB = 1'b0; sif.i_CS = 1'b0; sif.i_WE = 1'b0;
        step();
        sif.i_sram_address = 21'h00013;
        step(); step(); step();
        sif.i_CS = 1'b1; sif.i_WE = 1'b1;
        step();
        tb_dq_en = 1'b0;
        exp_err[2] = 1'b1;
        step(); step();
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL addr_chg_err got %b want %b", err, exp_err); end
        vectors++; if (bd_data !== 16'hA534 || wr_count !== exp_wr) begin
            miscompares++; $display("FAIL addr_chg_nocommit got %h/%0d want a534/%0d", bd_data, wr_count, exp_wr); end
    endtask

    task automatic test_alias();
        logic e; logic [15:0] d, hd; logic [1:0] drv, hdrv, zdrv;
        bd_addr = 10'h012;
        do_write(21'h00412, 16'hBEEF, 1'b0, 1'b0, 4);
        step(); step();
        vectors++; if (bd_data !== 16'hBEEF) begin miscompares++; $display("FAIL alias_wr got %h want beef", bd_data); end
        do_read(21'h1FC12, 1'b0, 1'b0, e, d, drv, hd, hdrv, zdrv);
        vectors++; if (d !== 16'hBEEF || drv !== 2'b11) begin
            miscompares++; $display("FAIL alias_rd got %h/%b want beef/11", d, drv); end
    endtask

    // Back-to-back random write/read pairs through aliased addresses; reads follow writes with no idle gap.
    task automatic test_back_to_back();
        logic e; logic [15:0] d, hd, expd, mask; logic [1:0] drv, hdrv, zdrv;
        logic [20:0] a, ra; logic [15:0] wd; logic ub, lb, rub, rlb; int idx;
        for (int n = 0; n < 30; n++) begin
            a = 21'($urandom); wd = 16'($urandom);
            ub = ($urandom_range(0, 3) == 0); lb = ($urandom_range(0, 3) == 0);
            do_write(a, wd, ub, lb, $urandom_range(1, 5));
            idx = int'(a[MEM_AW-1:0]);
            ra = {11'($urandom), a[MEM_AW-1:0]};
            rub = ($urandom_range(0, 3) == 0); rlb = ($urandom_range(0, 3) == 0);
            do_read(ra, rub, rlb, e, d, drv, hd, hdrv, zdrv);
            expd = ref_mem[idx];
            mask = {{8{~rub & ref_vld[idx][1]}}, {8{~rlb & ref_vld[idx][0]}}};
            vectors++; if (e !== 1'b0 || drv !== {~rub, ~rlb} || zdrv !== 2'b00) begin
                miscompares++; $display("FAIL rnd_lanes[%0d] got early=%b drv=%b z=%b want 0/%b/00", n, e, drv, zdrv, {~rub, ~rlb}); end
            vectors++; if ((d & mask) !== (expd & mask) || (hd & mask) !== (expd & mask)) begin
                miscompares++; $display("FAIL rnd_data[%0d] addr %h got %h hold %h want %h mask %h", n, ra, d, hd, expd, mask); end
        end
        vectors++; if (wr_count !== exp_wr || rd_count !== exp_rd) begin
            miscompares++; $display("FAIL rnd_counts got %0d/%0d want %0d/%0d", wr_count, rd_count, exp_wr, exp_rd); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL rnd_err got %b want %b", err, exp_err); end
    endtask

    task automatic test_reset_mid_read();
        sif.i_sram_address = 21'h00012; sif.i_UB = 1'b0; sif.i_LB = 1'b0;
        sif.i_WE = 1'b1; sif.i_CS = 1'b0; sif.i_OE = 1'b0;
        repeat (RD_LAT + 2) step();
        vectors++; if (sif.dq_drv !== 2'b11) begin miscompares++; $display("FAIL mid_read_drive got %b want 11", sif.dq_drv); end
        #1 reset = 1'b0;
        #1;
        vectors++; if (sif.dq_drv !== 2'b00 || ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_read got bus %b ready %b want 00/0", sif.dq_drv, ready); end
        vectors++; if (err !== 3'b000 || rd_count !== 16'd0) begin
            miscompares++; $display("FAIL reset_mid_read_state got err %b rd %0d want 000/0", err, rd_count); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        exp_wr = '0; exp_rd = '0; exp_err = '0;
        for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; ref_vld[i] = 2'b00; end
        test_reset();
        test_write();
        test_read();
        test_byte_lanes();
        test_errors();
        test_alias();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_sram_responder.md
# async_sram_responder

Synthesizable pin-level model of a 16-bit asynchronous SRAM (CS/OE/WE/UB/LB, active-low controls) that responds to the SRAM controller's pin interface inside the same 200 MHz i_clk domain. It enforces power-up wait, read access latency, minimum write pulse, byte-lane masking and output hold. It flags protocol violations as sticky error bits. Used as the on-chip device end for controller bring-up and loopback regression, and as an FPGA stand-in when no external SRAM is fitted.

## Interface
- MEM_AW, 10: implemented depth 2^MEM_AW words; address bits above MEM_AW-1 ignored (aliasing).
- RD_LAT, 2: cycles from access start (address stable) to data driven; legal 1..7.
- WR_MIN, 3: minimum WE-low cycles for a write to commit; legal 1..7.
- POWERUP_CYC, 40000: cycles after reset before accesses are honoured.
- i_clk  in  1  clock, 200 MHz.
- reset  in  1  asynchronous, active-low.
- i_sram_address  in  21  pin address.
- io_sram_data  inout  16  pin data; driven per byte lane only in READ_DRIVE/READ_HOLD, else Z.
- i_CS, i_OE, i_WE, i_UB, i_LB  in  1 each  active-low controls.
- i_bd_addr  in  MEM_AW  backdoor read address.
- o_bd_data  out  16  backdoor read data, registered, 1-cycle latency.
- o_ready  out  1  power-up complete.
- o_err  out  3  sticky: [0] access during power-up, [1] short write pulse, [2] address change during write.
- o_wr_count, o_rd_count  out  16 each  committed writes / completed reads, wrapping.

## Operation
- Reset values: o_ready=0, o_err=0, counters=0, o_bd_data=0, bus Z, state POWERUP. Memory contents not reset.
- Pins are same-clock-domain; sampled directly, no synchronizers.
- POWERUP: count POWERUP_CYC cycles, then o_ready=1, go IDLE. Any cycle with i_CS=0 sets o_err[0]; access ignored.
- IDLE: i_CS=0 & i_WE=0 → WRITE_PULSE (WE wins over OE; bus stays Z). i_CS=0 & i_OE=0 & i_WE=1 → READ_ACCESS. Latch address on entry.
- READ_ACCESS: cnt increments while address equals latched value; address change → relatch, cnt restarts at 1. cnt==RD_LAT → READ_DRIVE. CS or OE high → IDLE, no read counted.
- READ_DRIVE: drive mem[addr]; upper lane only when i_UB=0, lower only when i_LB=0; lane enables follow UB/LB each cycle. Address change → READ_ACCESS (bus Z, restart). CS/OE high or WE low → READ_HOLD, o_rd_count+1.
- READ_HOLD: keep last driven data one cycle (output hold), then Z, → IDLE.
- WRITE_PULSE: capture io_sram_data and UB/LB every low cycle; cnt++. Address change → o_err[2], abort, → WRITE_WAIT. WE or CS high: cnt≥WR_MIN → commit last captured data to enabled lanes, o_wr_count+1; else o_err[1], no commit. → IDLE.
- WRITE_WAIT: ignore pins until WE and CS both high → IDLE.
- Backdoor port independent of pin state; same-address same-cycle commit: o_bd_data returns old data.
- Reset mid-operation: bus Z immediately (async), in-flight write dropped, re-enter POWERUP.

## Timing
- Read: first edge sampling CS=OE=0 is edge 0; data valid on bus after edge RD_LAT+1 (default edge 3) with stable address.
- Write commit at the edge sampling WE high; readable via backdoor 2 edges later.
- Turnaround: bus Z in the cycle after READ_HOLD; a write immediately after a read sees no contention.
- Counters and error bits update on the edge that decides the event.

## Structure
- Package sram_pins_pkg: state enum (POWERUP, IDLE, READ_ACCESS, READ_DRIVE, READ_HOLD, WRITE_PULSE, WRITE_WAIT), default parameter constants, o_err bit indices.
- Sub-module sram_byte_lane_mem: 2^MEM_AW×16 true dual-port RAM, per-byte write enables, registered backdoor read port.

## Test plan
- Reset, hold CS low at cycle 100 → o_err=3'b001, no write; o_ready rises after 40000 cycles.
- Write 16'hA55A to 0x00012, WE low 3 cycles, UB=LB=0 → o_wr_count=1; backdoor 0x012 = 16'hA55A.
- Read 0x00012, CS=OE=0 held → bus 16'hA55A from edge 3, one hold cycle after OE high, then Z; o_rd_count=1.
- Write 16'h1234 with UB=1, LB=0 over 16'hA55A → memory 16'hA534; read with UB=0, LB=1 → upper lane 8'hA5, lower Z.
- WE low 2 cycles → o_err[1] set, memory unchanged; address change mid-pulse → o_err[2], no commit.
- Address 0x00412 aliases 0x012 (MEM_AW=10); reset during READ_DRIVE → bus Z at once, o_ready=0.
